perf_monitor_sequencer: RTL and testbench

Controller that runs measurement windows on the stream performance monitor and reads the results back out.
- Clears the monitor via its command word and waits for the monitor's ready_to_read flag.
- Walks the per-stream counter addresses and emits one AXI-stream beat per stream, with the window index attached.
- Sits between the monitor's command/counter_value ports and the result DMA / host stream.

---
 rtl/perf_seq_pkg.sv | 47 ++++
 rtl/perf_seq_axis_out.sv | 58 +++++
 rtl/perf_monitor_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_perf_monitor_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_seq_pkg.sv
// Shared types, command-word layout and result-beat layout for the
// perf_monitor_sequencer block.
package perf_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    WAIT   = 3'd2,
    SELECT = 3'd3,
    SEND   = 3'd4
  } seq_state_e;

  localparam int unsigned CMD_W        = 32;
  localparam int unsigned CMD_RST_BIT  = 6;
  localparam int unsigned CMD_ADDR_LSB = 1;
  localparam int unsigned CMD_ADDR_W   = 5;

  localparam int unsigned TD_W       = 64;
  localparam int unsigned TD_CNT_LSB = 0;
  localparam int unsigned TD_CNT_W   = 32;
  localparam int unsigned TD_IDX_LSB = 40;
  localparam int unsigned TD_IDX_W   = 8;
  localparam int unsigned TD_WIN_LSB = 48;
  localparam int unsigned TD_WIN_W   = 16;

  function automatic logic [CMD_W-1:0] mon_cmd(input logic rst_bit,
                                               input logic [CMD_ADDR_W-1:0] addr);
    logic [CMD_W-1:0] c;
    c = 32'd0;
    c[CMD_RST_BIT] = rst_bit;
    c[CMD_ADDR_LSB +: CMD_ADDR_W] = addr;
    return c;
  endfunction

  // Bits 39:32 stay zero as padding between stream index and count.
  function automatic logic [TD_W-1:0] pack_beat(input logic [TD_WIN_W-1:0] win,
                                                input logic [TD_IDX_W-1:0] idx,
                                                input logic [TD_CNT_W-1:0] cnt);
    logic [TD_W-1:0] d;
    d = 64'd0;
    d[TD_WIN_LSB +: TD_WIN_W] = win;
    d[TD_IDX_LSB +: TD_IDX_W] = idx;
    d[TD_CNT_LSB +: TD_CNT_W] = cnt;
    return d;
  endfunction

endpackage

// File: rtl/perf_seq_axis_out.sv
// Single-entry AXI-stream holding register: loaded once per beat, held
// stable until the downstream handshake.
module perf_seq_axis_out
  import perf_seq_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [TD_W-1:0] load_data,
  input  logic            load_last,
  input  logic            tready,
  output logic            tvalid,
  output logic [TD_W-1:0] tdata,
  output logic            tlast,
  output logic            accept
);

  logic            tvalid_q, tvalid_d;
  logic [TD_W-1:0] tdata_q, tdata_d;
  logic            tlast_q, tlast_d;

  assign accept = tvalid_q && tready;

  // Next-state of the holding register.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = load_data;
      tlast_d  = load_last;
    end else if (accept) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Holding register flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= 64'd0;
      tlast_q  <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  assign tvalid = tvalid_q;
  assign tdata  = tdata_q;
  assign tlast  = tlast_q;

endmodule

// File: rtl/perf_monitor_sequencer.sv
// Runs clear/wait/readout windows on the stream performance monitor and emits
// one result beat per stream. Optional watchdog: define PERF_SEQ_WATCHDOG_EN.
module perf_monitor_sequencer
  import perf_seq_pkg::*;
#(
  parameter int unsigned INPUT_STREAMS = 2,
  parameter int unsigned CLEAR_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 2
`ifdef PERF_SEQ_WATCHDOG_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'h0010_0000
`endif
)(
  input  logic        aclk,
  input  logic        reset,
  input  logic        start,
  input  logic        continuous,
  output logic        busy,
  output logic        done,
  output logic [15:0] window_count,
  output logic [31:0] mon_command,
  input  logic        mon_ready_to_read,
  input  logic [31:0] mon_counter_value,
  output logic        M_AXIS_TVALID,
  output logic [63:0] M_AXIS_TDATA,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
`ifdef PERF_SEQ_WATCHDOG_EN
  , output logic      error
`endif
);

  localparam logic [CMD_ADDR_W-1:0] LAST_IDX    = CMD_ADDR_W'(INPUT_STREAMS - 1);
  localparam logic [CMD_ADDR_W-1:0] IDX_ZERO    = CMD_ADDR_W'(0);
  localparam logic [CMD_ADDR_W-1:0] IDX_ONE     = CMD_ADDR_W'(1);
  localparam logic [31:0]           CLEAR_LAST  = 32'(CLEAR_CYCLES - 1);
  localparam logic [31:0]           SETTLE_LAST = 32'(SETTLE_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [CMD_ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]           phase_cnt_q, phase_cnt_d;
  logic                  wait_armed_q, wait_armed_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [15:0]           window_count_q, window_count_d;
  logic [31:0]           mon_command_q, mon_command_d;

  logic            out_load_s, out_last_s, out_accept_s;
  logic [TD_W-1:0] out_data_s;
  logic            start_ok_s, wd_fire_s;

`ifdef PERF_SEQ_WATCHDOG_EN
  logic [31:0] wd_q, wd_d;
  logic        error_q, error_d;

  // Timeout only wins when the ready flag is not being taken this cycle.
  assign wd_fire_s  = (state_q == WAIT) && !(wait_armed_q && mon_ready_to_read)
                      && (wd_q == TIMEOUT_CYCLES - 32'd1);
  assign start_ok_s = start && !error_q;
  assign error      = error_q;

  // Watchdog timer and sticky error flag next-state.
  always_comb begin
    wd_d    = 32'd0;
    error_d = error_q;
    if (state_q == WAIT) begin
      wd_d = wd_q + 32'd1;
    end else begin
      wd_d = 32'd0;
    end
    if (wd_fire_s) begin
      error_d = 1'b1;
    end else begin
      error_d = error_q;
    end
  end

  // Watchdog flops.
  always_ff @(posedge aclk) begin
    if (reset) begin
      wd_q    <= 32'd0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end
`else
  assign wd_fire_s  = 1'b0;
  assign start_ok_s = start;
`endif

  // Sequencer next-state; every output is registered from these _d values.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    phase_cnt_d    = phase_cnt_q;
    wait_armed_d   = wait_armed_q;
    window_count_d = window_count_q;
    mon_command_d  = mon_command_q;
    done_d         = 1'b0;
    out_load_s     = 1'b0;
    out_last_s     = 1'b0;
    out_data_s     = 64'd0;
    case (state_q)
      IDLE: begin
        if (start_ok_s) begin
          state_d       = CLEAR;
          phase_cnt_d   = 32'd0;
          mon_command_d = mon_cmd(1'b1, IDX_ZERO);
        end else begin
          mon_command_d = 32'd0;
        end
      end
      CLEAR: begin
        if (phase_cnt_q == CLEAR_LAST) begin
          state_d       = WAIT;
          wait_armed_d  = 1'b0;
          mon_command_d = 32'd0;
        end else begin
          phase_cnt_d = phase_cnt_q + 32'd1;
        end
      end
      WAIT: begin
        // The monitor drops its flag one cycle late, so the first WAIT cycle is skipped.
        if (wait_armed_q && mon_ready_to_read) begin
          state_d       = SELECT;
          idx_d         = IDX_ZERO;
          phase_cnt_d   = 32'd0;
          mon_command_d = mon_cmd(1'b0, IDX_ZERO);
        end else if (wd_fire_s) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          wait_armed_d = 1'b1;
        end
      end
      SELECT: begin
        if (phase_cnt_q == SETTLE_LAST) begin
          state_d    = SEND;
          out_load_s = 1'b1;
          out_last_s = (idx_q == LAST_IDX);
          out_data_s = pack_beat(window_count_q, 8'(idx_q), mon_counter_value);
        end else begin
          phase_cnt_d = phase_cnt_q + 32'd1;
        end
      end
      SEND: begin
        if (out_accept_s) begin
          if (idx_q == LAST_IDX) begin
            window_count_d = window_count_q + 16'd1;
            if (continuous) begin
              state_d       = CLEAR;
              phase_cnt_d   = 32'd0;
              mon_command_d = mon_cmd(1'b1, IDX_ZERO);
            end else begin
              state_d       = IDLE;
              done_d        = 1'b1;
              mon_command_d = 32'd0;
            end
          end else begin
            state_d       = SELECT;
            idx_d         = idx_q + IDX_ONE;
            phase_cnt_d   = 32'd0;
            mon_command_d = mon_cmd(1'b0, idx_q + IDX_ONE);
          end
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d       = IDLE;
        mon_command_d = 32'd0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Sequencer flops.
  always_ff @(posedge aclk) begin
    if (reset) begin
      state_q        <= IDLE;
      idx_q          <= IDX_ZERO;
      phase_cnt_q    <= 32'd0;
      wait_armed_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      window_count_q <= 16'd0;
      mon_command_q  <= 32'd0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      phase_cnt_q    <= phase_cnt_d;
      wait_armed_q   <= wait_armed_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      window_count_q <= window_count_d;
      mon_command_q  <= mon_command_d;
    end
  end

  perf_seq_axis_out u_axis_out (
    .clk       (aclk),
    .reset     (reset),
    .load      (out_load_s),
    .load_data (out_data_s),
    .load_last (out_last_s),
    .tready    (M_AXIS_TREADY),
    .tvalid    (M_AXIS_TVALID),
    .tdata     (M_AXIS_TDATA),
    .tlast     (M_AXIS_TLAST),
    .accept    (out_accept_s)
  );

  assign busy         = busy_q;
  assign done         = done_q;
  assign window_count = window_count_q;
  assign mon_command  = mon_command_q;

endmodule

// File: tb/tb_perf_monitor_sequencer.sv
// Directed bench for perf_monitor_sequencer with a behavioural monitor and a
// beat-queue model; define PERF_SEQ_WATCHDOG_EN to also run the timeout test.
module tb_perf_monitor_sequencer;

  localparam int NSTREAM = 2;
  localparam int SETTLE  = 2;
`ifdef PERF_SEQ_WATCHDOG_EN
  localparam int          COUNT_MAIN = 40;
  localparam logic [63:0] LIT0 = 64'h0000_0000_0000_0028;
  localparam logic [63:0] LIT1 = 64'h0000_0100_0000_0014;
`else
  localparam int          COUNT_MAIN = 100;
  localparam logic [63:0] LIT0 = 64'h0000_0000_0000_0064;
  localparam logic [63:0] LIT1 = 64'h0000_0100_0000_0032;
`endif

  logic        aclk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, continuous = 1'b0, tready = 1'b1;
  logic        busy, done, tvalid, tlast;
  logic [15:0] window_count;
  logic [31:0] mon_command, mon_counter_value;
  logic        mon_ready_to_read;
  logic [63:0] tdata;
`ifdef PERF_SEQ_WATCHDOG_EN
  logic        error;
`endif

  always #5 aclk = ~aclk;

  perf_monitor_sequencer #(
    .INPUT_STREAMS(NSTREAM), .CLEAR_CYCLES(2), .SETTLE_CYCLES(SETTLE)
`ifdef PERF_SEQ_WATCHDOG_EN
    , .TIMEOUT_CYCLES(32'd50)
`endif
  ) dut (
    .aclk(aclk), .reset(reset), .start(start), .continuous(continuous),
    .busy(busy), .done(done), .window_count(window_count),
    .mon_command(mon_command), .mon_ready_to_read(mon_ready_to_read),
    .mon_counter_value(mon_counter_value),
    .M_AXIS_TVALID(tvalid), .M_AXIS_TDATA(tdata), .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready)
`ifdef PERF_SEQ_WATCHDOG_EN
    , .error(error)
`endif
  );

  // Behavioural stream monitor: stream0 counts every cycle, stream1 on even cycles.
  int          count_cycles = COUNT_MAIN;
  int          mcyc = 0;
  logic [31:0] c0 = 32'd0, c1 = 32'd0;
  logic        mon_rdy_r = 1'b0, mon_rst_dly = 1'b0, mon_block = 1'b0;

  always @(posedge aclk) begin
    mon_rst_dly <= mon_command[6];
    if (mon_command[6]) begin
      mcyc <= 0; c0 <= 32'd0; c1 <= 32'd0;
    end else if (mcyc < count_cycles) begin
      mcyc <= mcyc + 1;
      c0 <= c0 + 32'd1;
      if (mcyc % 2 == 0) c1 <= c1 + 32'd1;
    end
    if (mon_rst_dly) mon_rdy_r <= 1'b0;
    else if (!mon_command[6] && mcyc >= count_cycles) mon_rdy_r <= 1'b1;
  end

  assign mon_ready_to_read = mon_rdy_r & ~mon_block;
  assign mon_counter_value = (mon_command[5:1] == 5'd0) ? c0 :
                             (mon_command[5:1] == 5'd1) ? c1 : 32'd0;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: a window produces one beat per stream tagged with the pre-increment window index.
  typedef struct { logic [63:0] data; logic last; } beat_t;
  beat_t       exp_q[$];
  logic [63:0] got_q[$];
  logic [15:0] model_wc = 16'd0;
  int          clear_cyc = 0, done_cnt = 0;

  function automatic logic [31:0] stream_count(input int s);
    return (s == 0) ? 32'(count_cycles) : 32'((count_cycles + 1) / 2);
  endfunction

  task automatic push_window();
    for (int s = 0; s < NSTREAM; s++) begin
      beat_t b;
      b.data = {model_wc, 8'(s), 8'h00, stream_count(s)};
      b.last = (s == NSTREAM - 1);
      exp_q.push_back(b);
    end
    model_wc = model_wc + 16'd1;
  endtask

  // Per-cycle compare: beats against the model, hold-while-stalled, beat spacing.
  initial begin
    logic        prev_v, prev_r, prev_l;
    logic [63:0] prev_d;
    int          gap;
    beat_t       e;
    prev_v = 1'b0; prev_r = 1'b0; prev_l = 1'b0; prev_d = 64'd0; gap = 1000;
    forever begin
      @(negedge aclk);
      if (reset) begin
        prev_v = 1'b0; gap = 1000;
      end else begin
        if (mon_command == 32'h40) clear_cyc++;
        if (done) done_cnt++;
        if (prev_v && !prev_r) begin
          check("hold_valid", 64'(tvalid), 64'd1);
          check("hold_data", tdata, prev_d);
          check("hold_last", 64'(tlast), 64'(prev_l));
        end
        if (tvalid && tready) begin
          check("beat_gap_ok", 64'(gap >= SETTLE), 64'd1);
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got 0x%0h expected no beat", tdata);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", tdata, e.data);
            check("beat_last", 64'(tlast), 64'(e.last));
          end
          got_q.push_back(tdata);
          gap = 0;
        end else begin
          gap++;
        end
        prev_v = tvalid; prev_r = tready; prev_d = tdata; prev_l = tlast;
      end
    end
  end

  task automatic do_reset();
    @(posedge aclk); #1 reset = 1'b1;
    exp_q.delete(); model_wc = 16'd0;
    repeat (2) @(posedge aclk);
    #1 reset = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge aclk); #1 start = 1'b1;
    @(posedge aclk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (done !== 1'b1 && n < budget);
    check(name, 64'(done), 64'd1);
    @(negedge aclk);
    check({name, "_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n, base, wcyc;
    // Test 1: reset state, then a basic window.
    do_reset();
    @(negedge aclk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    check("rst_cmd", 64'(mon_command), 64'd0);
    check("rst_wc", 64'(window_count), 64'd0);
    got_q.delete();
    push_window();
    pulse_start();
    @(negedge aclk);
    check("t1_clear1_cmd", 64'(mon_command), 64'h40);
    check("t1_clear1_busy", 64'(busy), 64'd1);
    @(negedge aclk);
    check("t1_clear2_cmd", 64'(mon_command), 64'h40);
    @(negedge aclk);
    check("t1_wait_cmd", 64'(mon_command), 64'd0);
    wait_done(400, "t1_done");
    check("t1_wc", 64'(window_count), 64'd1);
    check("t1_nbeats", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t1_beat0_lit", got_q[0], LIT0);
      check("t1_beat1_lit", got_q[1], LIT1);
    end
    check("t1_busy_after", 64'(busy), 64'd0);

    // Test 2: stall the first beat for 20 cycles.
    do_reset();
    got_q.delete();
    tready = 1'b0;
    push_window();
    pulse_start();
    n = 0;
    do begin @(negedge aclk); n++; end while (tvalid !== 1'b1 && n < 400);
    check("t2_first_valid", 64'(tvalid), 64'd1);
    repeat (20) @(posedge aclk);
    #1;
    check("t2_no_beat_stalled", 64'(got_q.size()), 64'd0);
    tready = 1'b1;
    wait_done(100, "t2_done");
    check("t2_nbeats", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t2_beat0_lit", got_q[0], LIT0);
      check("t2_beat1_lit", got_q[1], LIT1);
    end

    // Test 3: continuous windows; drop continuous during the third window.
    do_reset();
    got_q.delete();
    continuous = 1'b1;
    repeat (3) push_window();
    clear_cyc = 0; done_cnt = 0;
    pulse_start();
    n = 0;
    do begin @(negedge aclk); n++; end while (got_q.size() < 5 && n < 1500);
    continuous = 1'b0;
    wait_done(400, "t3_done");
    check("t3_nbeats", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < got_q.size(); i++)
      check("t3_win_idx", 64'(got_q[i][63:48]), 64'(i / 2));
    check("t3_clear_cycles", 64'(clear_cyc), 64'd6);
    check("t3_done_count", 64'(done_cnt), 64'd1);
    check("t3_wc", 64'(window_count), 64'd3);

    // Test 4: reset while selecting stream 1.
    do_reset();
    got_q.delete();
    push_window();
    pulse_start();
    n = 0;
    do begin @(negedge aclk); n++; end while (mon_command !== 32'h2 && n < 400);
    check("t4_reach_sel1", 64'(mon_command), 64'h2);
    reset = 1'b1;
    exp_q.delete(); model_wc = 16'd0;
    @(negedge aclk);
    check("t4_rst_tvalid", 64'(tvalid), 64'd0);
    check("t4_rst_cmd", 64'(mon_command), 64'd0);
    check("t4_rst_busy", 64'(busy), 64'd0);
    check("t4_rst_wc", 64'(window_count), 64'd0);
    reset = 1'b0;
    repeat (20) @(negedge aclk);
    check("t4_no_partial_beat", 64'(got_q.size()), 64'd1);
    push_window();
    pulse_start();
    wait_done(400, "t4_done");
    check("t4_nbeats", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      check("t4_beat0_lit", got_q[1], LIT0);
      check("t4_beat1_lit", got_q[2], LIT1);
    end
    check("t4_wc", 64'(window_count), 64'd1);

    // Test 5: start while busy is ignored; window_count wraps.
    base = got_q.size();
    done_cnt = 0;
    push_window();
    pulse_start();
    repeat (3) @(posedge aclk);
    pulse_start();
    wait_done(400, "t5_done");
    repeat (30) @(negedge aclk);
    check("t5_idle", 64'(busy), 64'd0);
    check("t5_nbeats", 64'(got_q.size() - base), 64'd2);
    check("t5_done_count", 64'(done_cnt), 64'd1);
    check("t5_wc", 64'(window_count), 64'd2);
    force dut.window_count_q = 16'hFFFF;
    @(posedge aclk);
    @(negedge aclk);
    release dut.window_count_q;
    @(negedge aclk);
    check("t5_preload", 64'(window_count), 64'hFFFF);
    model_wc = 16'hFFFF;
    count_cycles = 1;
    push_window();
    pulse_start();
    wait_done(200, "t5_wrap_done");
    check("t5_wrap_wc", 64'(window_count), 64'd0);
    check("t5_wrap_beat_lit", got_q[got_q.size() - 1], 64'hFFFF_0100_0000_0001);
    check("t5_queue_drained", 64'(exp_q.size()), 64'd0);
    count_cycles = COUNT_MAIN;

`ifdef PERF_SEQ_WATCHDOG_EN
    // Test 6: watchdog timeout with the ready flag held low.
    do_reset();
    base = got_q.size();
    mon_block = 1'b1;
    pulse_start();
    n = 0; wcyc = 0;
    do begin
      @(negedge aclk); n++;
      if (busy && mon_command == 32'd0) wcyc++;
    end while (done !== 1'b1 && n < 300);
    check("t6_done", 64'(done), 64'd1);
    check("t6_error", 64'(error), 64'd1);
    check("t6_wait_cycles", 64'(wcyc), 64'd50);
    check("t6_wc", 64'(window_count), 64'd0);
    pulse_start();
    repeat (10) @(negedge aclk);
    check("t6_start_ignored", 64'(busy), 64'd0);
    check("t6_error_sticky", 64'(error), 64'd1);
    check("t6_no_beats", 64'(got_q.size() - base), 64'd0);
    mon_block = 1'b0;
    do_reset();
    @(negedge aclk);
    check("t6_error_cleared", 64'(error), 64'd0);
`else
    wcyc = 0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
